mor1kx_dpram_be_sclk: RTL

//  Single-clock dual-port RAM (one read port, one write port) with per-byte write enables.

---
 rtl/mor1kx_dpram_be_sclk.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mor1kx_dpram_be_sclk.sv
// Single-clock dual-port RAM with one read port, one write port and byte enables.
// Read-during-write bypass is applied per byte. An optional register stage follows the read.
// A clear engine zeroes the array after reset or on request. The array is busy while it runs.
module mor1kx_dpram_be_sclk #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int ENABLE_BYPASS  = 1,
    parameter int OUTPUT_REG     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    input  logic                    clear_req,
    output logic                    busy
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam bit BYPASS_ON = (ENABLE_BYPASS != 0);
    localparam bit CLEAR_AT_RESET = (CLEAR_ON_RESET != 0);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [ADDR_WIDTH-1:0]   clr_addr_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    rd_acc;
    logic                    wr_acc;
    logic                    same_addr;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH-1:0]   din_r;
    logic [NUM_BYTES-1:0]    mask;
    logic                    valid1;
    logic [DATA_WIDTH-1:0]   stage1_data;

    // Ports are blocked while the clear engine owns the array.
    assign busy      = (state == CLEAR);
    assign rd_acc    = re & ~busy;
    assign wr_acc    = we & ~busy;
    assign same_addr = rd_acc & wr_acc & (raddr == waddr);

    // Clear-engine state and sweep address; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR_AT_RESET ? CLEAR : IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // Sweep every address once, then hand the array back to the ports.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            IDLE: begin
                clr_addr_next = '0;
                if (clear_req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_next    = IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                clr_addr_next = '0;
            end
        endcase
    end

    // Array write port: the clear sweep has priority, otherwise byte-masked user writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[clr_addr] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (be[i]) begin
                        mem[waddr][8*i +: 8] <= din[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read stage: capture the old word plus which bytes are overridden by a colliding write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            din_r  <= '0;
            mask   <= '0;
            valid1 <= 1'b0;
        end else begin
            valid1 <= rd_acc;
            if (rd_acc) begin
                rdata <= mem[raddr];
                if (BYPASS_ON && same_addr) begin
                    mask  <= be;
                    din_r <= din;
                end else begin
                    mask <= '0;
                end
            end
        end
    end

    // Merge bypassed bytes over the array word.
    always_comb begin
        stage1_data = rdata;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (mask[i]) begin
                stage1_data[8*i +: 8] = din_r[8*i +: 8];
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] pipe;
            logic                  pipe_valid;

            // Optional output register loads only when stage 1 holds a fresh read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe       <= '0;
                    pipe_valid <= 1'b0;
                end else begin
                    pipe_valid <= valid1;
                    if (valid1) begin
                        pipe <= stage1_data;
                    end
                end
            end

            assign dout       = pipe;
            assign dout_valid = pipe_valid;
        end else begin : g_no_out_reg
            assign dout       = stage1_data;
            assign dout_valid = valid1;
        end
    endgenerate

endmodule
